// File: rtl/tl_ul_arb2.sv
`default_nettype none
// ============================================================================
// Module : tl_ul_arb2
// Brief  : Two-master TileLink-UL arbiter. Round-robin A grant with burst lock,
//          D routed by source MSB, per-master outstanding-request limit.
// Rev    : 1.0
// ============================================================================
module tl_ul_arb2 #(
    parameter int SRC_W        = 1,
    parameter int SIZE_W       = 3,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              m0_a_valid,
    output logic              m0_a_ready,
    input  logic [2:0]        m0_a_opcode,
    input  logic [2:0]        m0_a_param,
    input  logic [SIZE_W-1:0] m0_a_size,
    input  logic [SRC_W-1:0]  m0_a_source,
    input  logic [31:0]       m0_a_address,
    input  logic [3:0]        m0_a_mask,
    input  logic [31:0]       m0_a_data,
    output logic              m0_d_valid,
    input  logic              m0_d_ready,
    output logic [2:0]        m0_d_opcode,
    output logic [SIZE_W-1:0] m0_d_size,
    output logic [SRC_W-1:0]  m0_d_source,
    output logic [31:0]       m0_d_data,
    output logic              m0_d_error,

    input  logic              m1_a_valid,
    output logic              m1_a_ready,
    input  logic [2:0]        m1_a_opcode,
    input  logic [2:0]        m1_a_param,
    input  logic [SIZE_W-1:0] m1_a_size,
    input  logic [SRC_W-1:0]  m1_a_source,
    input  logic [31:0]       m1_a_address,
    input  logic [3:0]        m1_a_mask,
    input  logic [31:0]       m1_a_data,
    output logic              m1_d_valid,
    input  logic              m1_d_ready,
    output logic [2:0]        m1_d_opcode,
    output logic [SIZE_W-1:0] m1_d_size,
    output logic [SRC_W-1:0]  m1_d_source,
    output logic [31:0]       m1_d_data,
    output logic              m1_d_error,

    output logic              s_a_valid,
    input  logic              s_a_ready,
    output logic [2:0]        s_a_opcode,
    output logic [2:0]        s_a_param,
    output logic [SIZE_W-1:0] s_a_size,
    output logic [SRC_W:0]    s_a_source,
    output logic [31:0]       s_a_address,
    output logic [3:0]        s_a_mask,
    output logic [31:0]       s_a_data,
    input  logic              s_d_valid,
    output logic              s_d_ready,
    input  logic [2:0]        s_d_opcode,
    input  logic [SIZE_W-1:0] s_d_size,
    input  logic [SRC_W:0]    s_d_source,
    input  logic [31:0]       s_d_data,
    input  logic              s_d_error
);

    localparam int BEAT_W = 1 << SIZE_W;
    localparam int INF_W  = 4;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic                lock_idx, lock_idx_nxt;
    logic                rr_ptr, rr_ptr_nxt;
    logic                hold, hold_nxt;
    logic                hold_idx, hold_idx_nxt;
    logic [BEAT_W-1:0]   a_beats_left, a_beats_left_nxt;
    logic [BEAT_W-1:0]   d_beats_left, d_beats_left_nxt;
    logic [INF_W-1:0]    inflight     [2];
    logic [INF_W-1:0]    inflight_nxt [2];

    logic [1:0]          eligible;
    logic                grant;
    logic                a_valid_int;
    logic                a_fire;
    logic [BEAT_W-1:0]   a_beats;
    logic                d_idx;
    logic                d_fire;
    logic                d_last;
    logic [BEAT_W-1:0]   d_beats;
    logic [1:0]          a_inc;
    logic [1:0]          d_dec;

    function automatic logic [BEAT_W-1:0] beats_of(input logic [SIZE_W-1:0] size);
        if (size > SIZE_W'(2)) return BEAT_W'(1) << (size - SIZE_W'(2));
        return BEAT_W'(1);
    endfunction

    assign eligible[0] = m0_a_valid && (inflight[0] < INF_W'(MAX_INFLIGHT));
    assign eligible[1] = m1_a_valid && (inflight[1] < INF_W'(MAX_INFLIGHT));

    // A stalled offer keeps its grant so s_a_valid is never withdrawn.
    always_comb begin
        grant = 1'b0;
        if (state == ST_LOCKED)
            grant = lock_idx;
        else if (hold && eligible[hold_idx])
            grant = hold_idx;
        else if (eligible[0] && eligible[1])
            grant = rr_ptr;
        else
            grant = eligible[1];
    end

    assign a_valid_int = (state == ST_LOCKED) ? (grant ? m1_a_valid : m0_a_valid)
                                              : eligible[grant];
    assign s_a_valid   = !reset && a_valid_int;
    assign m0_a_ready  = s_a_valid && s_a_ready && !grant;
    assign m1_a_ready  = s_a_valid && s_a_ready &&  grant;
    assign s_a_opcode  = grant ? m1_a_opcode  : m0_a_opcode;
    assign s_a_param   = grant ? m1_a_param   : m0_a_param;
    assign s_a_size    = grant ? m1_a_size    : m0_a_size;
    assign s_a_source  = {grant, grant ? m1_a_source : m0_a_source};
    assign s_a_address = grant ? m1_a_address : m0_a_address;
    assign s_a_mask    = grant ? m1_a_mask    : m0_a_mask;
    assign s_a_data    = grant ? m1_a_data    : m0_a_data;

    assign a_fire  = s_a_valid && s_a_ready;
    assign a_beats = (s_a_opcode == 3'd0 || s_a_opcode == 3'd1) ? beats_of(s_a_size) : BEAT_W'(1);

    assign d_idx       = s_d_source[SRC_W];
    assign m0_d_valid  = !reset && s_d_valid && !d_idx;
    assign m1_d_valid  = !reset && s_d_valid &&  d_idx;
    assign s_d_ready   = !reset && (d_idx ? m1_d_ready : m0_d_ready);
    assign m0_d_opcode = s_d_opcode;
    assign m1_d_opcode = s_d_opcode;
    assign m0_d_size   = s_d_size;
    assign m1_d_size   = s_d_size;
    assign m0_d_source = s_d_source[SRC_W-1:0];
    assign m1_d_source = s_d_source[SRC_W-1:0];
    assign m0_d_data   = s_d_data;
    assign m1_d_data   = s_d_data;
    assign m0_d_error  = s_d_error;
    assign m1_d_error  = s_d_error;

    assign d_fire  = s_d_valid && s_d_ready;
    assign d_beats = (s_d_opcode == 3'd1) ? beats_of(s_d_size) : BEAT_W'(1);
    // d_beats_left==0 means the next D beat starts a new message.
    assign d_last  = (d_beats_left == '0) ? (d_beats == BEAT_W'(1))
                                          : (d_beats_left == BEAT_W'(1));

    always_comb begin
        state_nxt        = state;
        lock_idx_nxt     = lock_idx;
        rr_ptr_nxt       = rr_ptr;
        hold_nxt         = 1'b0;
        hold_idx_nxt     = grant;
        a_beats_left_nxt = a_beats_left;
        d_beats_left_nxt = d_beats_left;
        a_inc            = 2'b00;
        d_dec            = 2'b00;

        if (state == ST_IDLE) begin
            hold_nxt = s_a_valid && !s_a_ready;
            if (a_fire) begin
                a_inc[grant] = 1'b1;
                if (a_beats != BEAT_W'(1)) begin
                    state_nxt        = ST_LOCKED;
                    lock_idx_nxt     = grant;
                    a_beats_left_nxt = a_beats - BEAT_W'(1);
                end else begin
                    rr_ptr_nxt = ~grant;
                end
            end
        end else if (a_fire) begin
            a_beats_left_nxt = a_beats_left - BEAT_W'(1);
            if (a_beats_left == BEAT_W'(1)) begin
                state_nxt  = ST_IDLE;
                rr_ptr_nxt = ~lock_idx;
            end
        end

        if (d_fire) begin
            d_beats_left_nxt = (d_beats_left == '0) ? (d_beats - BEAT_W'(1))
                                                    : (d_beats_left - BEAT_W'(1));
            d_dec[d_idx]     = d_last;
        end

        for (int n = 0; n < 2; n++) begin
            inflight_nxt[n] = inflight[n];
            if (a_inc[n] && !d_dec[n])
                inflight_nxt[n] = inflight[n] + INF_W'(1);
            else if (d_dec[n] && !a_inc[n] && inflight[n] != '0)
                inflight_nxt[n] = inflight[n] - INF_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            lock_idx     <= 1'b0;
            rr_ptr       <= 1'b0;
            hold         <= 1'b0;
            hold_idx     <= 1'b0;
            a_beats_left <= '0;
            d_beats_left <= '0;
            inflight[0]  <= '0;
            inflight[1]  <= '0;
        end else begin
            state        <= state_nxt;
            lock_idx     <= lock_idx_nxt;
            rr_ptr       <= rr_ptr_nxt;
            hold         <= hold_nxt;
            hold_idx     <= hold_idx_nxt;
            a_beats_left <= a_beats_left_nxt;
            d_beats_left <= d_beats_left_nxt;
            inflight[0]  <= inflight_nxt[0];
            inflight[1]  <= inflight_nxt[1];
        end
    end

    // A final D beat for a master with nothing outstanding is a protocol error.
    no_d_underflow: assert property (@(posedge clock) disable iff (reset)
        !(d_fire && d_last && inflight[d_idx] == '0));

endmodule
`default_nettype wire

// File: tb/tb_tl_ul_arb2.sv
`default_nettype none
// ============================================================================
// Module : tb_tl_ul_arb2
// Brief  : Randomized scoreboard bench for tl_ul_arb2 with a message-level model.
// Rev    : 1.0
// ============================================================================
module tb_tl_ul_arb2;
    localparam int SRC_W        = 1;
    localparam int SIZE_W       = 3;
    localparam int MAX_INFLIGHT = 2;

    typedef struct {
        logic [2:0]        op;
        logic [2:0]        param;
        logic [SIZE_W-1:0] size;
        logic [SRC_W-1:0]  src;
        logic [31:0]       addr;
        logic [3:0]        mask;
        logic [31:0]       data;
        bit                first;
        bit                last;
    } abeat_t;

    typedef struct {
        logic [2:0]        op;
        logic [SIZE_W-1:0] size;
        logic [SRC_W:0]    src;
        logic [31:0]       data;
        logic              err;
        bit                last;
    } dbeat_t;

    logic clock, reset;
    logic              m_a_valid [2], m_a_ready [2];
    logic [2:0]        m_a_opcode [2], m_a_param [2];
    logic [SIZE_W-1:0] m_a_size [2];
    logic [SRC_W-1:0]  m_a_source [2];
    logic [31:0]       m_a_address [2], m_a_data [2];
    logic [3:0]        m_a_mask [2];
    logic              m_d_valid [2], m_d_ready [2], m_d_error [2];
    logic [2:0]        m_d_opcode [2];
    logic [SIZE_W-1:0] m_d_size [2];
    logic [SRC_W-1:0]  m_d_source [2];
    logic [31:0]       m_d_data [2];
    logic              s_a_valid, s_a_ready, s_d_valid, s_d_ready, s_d_error;
    logic [2:0]        s_a_opcode, s_a_param, s_d_opcode;
    logic [SIZE_W-1:0] s_a_size, s_d_size;
    logic [SRC_W:0]    s_a_source, s_d_source;
    logic [31:0]       s_a_address, s_a_data, s_d_data;
    logic [3:0]        s_a_mask;

    abeat_t exp_a [2][$];
    dbeat_t exp_d [2][$];
    dbeat_t slv_q [$];
    int checks = 0;
    int errors = 0;

    tl_ul_arb2 #(.SRC_W(SRC_W), .SIZE_W(SIZE_W), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
        .clock(clock), .reset(reset),
        .m0_a_valid(m_a_valid[0]), .m0_a_ready(m_a_ready[0]), .m0_a_opcode(m_a_opcode[0]),
        .m0_a_param(m_a_param[0]), .m0_a_size(m_a_size[0]), .m0_a_source(m_a_source[0]),
        .m0_a_address(m_a_address[0]), .m0_a_mask(m_a_mask[0]), .m0_a_data(m_a_data[0]),
        .m0_d_valid(m_d_valid[0]), .m0_d_ready(m_d_ready[0]), .m0_d_opcode(m_d_opcode[0]),
        .m0_d_size(m_d_size[0]), .m0_d_source(m_d_source[0]), .m0_d_data(m_d_data[0]),
        .m0_d_error(m_d_error[0]),
        .m1_a_valid(m_a_valid[1]), .m1_a_ready(m_a_ready[1]), .m1_a_opcode(m_a_opcode[1]),
        .m1_a_param(m_a_param[1]), .m1_a_size(m_a_size[1]), .m1_a_source(m_a_source[1]),
        .m1_a_address(m_a_address[1]), .m1_a_mask(m_a_mask[1]), .m1_a_data(m_a_data[1]),
        .m1_d_valid(m_d_valid[1]), .m1_d_ready(m_d_ready[1]), .m1_d_opcode(m_d_opcode[1]),
        .m1_d_size(m_d_size[1]), .m1_d_source(m_d_source[1]), .m1_d_data(m_d_data[1]),
        .m1_d_error(m_d_error[1]),
        .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode),
        .s_a_param(s_a_param), .s_a_size(s_a_size), .s_a_source(s_a_source),
        .s_a_address(s_a_address), .s_a_mask(s_a_mask), .s_a_data(s_a_data),
        .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_opcode(s_d_opcode),
        .s_d_size(s_d_size), .s_d_source(s_d_source), .s_d_data(s_d_data),
        .s_d_error(s_d_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int beats(input int size);
        return (size > 2) ? (1 << (size - 2)) : 1;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: message-level model of grant order and outstanding counts.
    initial begin : monitor
        bit     mid, owner, rr, stall, stall_idx, g, ev, idx, di;
        bit     elig [2];
        int     outst [2];
        abeat_t ea;
        dbeat_t ed;
        mid = 0; owner = 0; rr = 0; stall = 0; stall_idx = 0;
        outst[0] = 0; outst[1] = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                chk("rst_s_a_valid", s_a_valid, 0);
                chk("rst_s_d_ready", s_d_ready, 0);
                for (int n = 0; n < 2; n++) begin
                    chk($sformatf("rst_m%0d_a_ready", n), m_a_ready[n], 0);
                    chk($sformatf("rst_m%0d_d_valid", n), m_d_valid[n], 0);
                    exp_a[n].delete();
                    exp_d[n].delete();
                    outst[n] = 0;
                end
                mid = 0; rr = 0; stall = 0;
                continue;
            end
            for (int n = 0; n < 2; n++)
                elig[n] = m_a_valid[n] && (outst[n] < MAX_INFLIGHT);
            if (mid) begin
                g = owner; ev = m_a_valid[owner];
            end else if (stall && elig[stall_idx]) begin
                g = stall_idx; ev = 1;
            end else if (elig[0] && elig[1]) begin
                g = rr; ev = 1;
            end else begin
                g = elig[1]; ev = elig[0] || elig[1];
            end
            chk("s_a_valid", s_a_valid, ev);
            if (ev) chk("grant", s_a_source[SRC_W], g);
            for (int n = 0; n < 2; n++)
                chk($sformatf("m%0d_a_ready", n), m_a_ready[n], ev && (g == n) && s_a_ready);

            if (s_a_valid && s_a_ready) begin
                idx = s_a_source[SRC_W];
                if (exp_a[idx].size() == 0) begin
                    chk("a_unexpected_beat", 1, 0);
                end else begin
                    ea = exp_a[idx].pop_front();
                    chk("a_opcode", s_a_opcode, ea.op);
                    chk("a_param", s_a_param, ea.param);
                    chk("a_size", s_a_size, ea.size);
                    chk("a_source", s_a_source[SRC_W-1:0], ea.src);
                    chk("a_address", s_a_address, ea.addr);
                    chk("a_mask", s_a_mask, ea.mask);
                    chk("a_data", s_a_data, ea.data);
                    if (ea.first) outst[idx]++;
                    if (ea.last) begin
                        mid = 0; rr = !idx;
                    end else begin
                        mid = 1; owner = idx;
                    end
                end
                stall = 0;
            end else begin
                stall = ev && !mid;
                stall_idx = g;
            end

            di = s_d_source[SRC_W];
            chk("d_valid_routed", m_d_valid[di], s_d_valid);
            chk("d_valid_other", m_d_valid[!di], 0);
            chk("s_d_ready", s_d_ready, m_d_ready[di]);
            if (s_d_valid && s_d_ready) begin
                if (exp_d[di].size() == 0) begin
                    chk("d_unexpected_beat", 1, 0);
                end else begin
                    ed = exp_d[di].pop_front();
                    chk("d_opcode", m_d_opcode[di], ed.op);
                    chk("d_size", m_d_size[di], ed.size);
                    chk("d_source", m_d_source[di], ed.src[SRC_W-1:0]);
                    chk("d_data", m_d_data[di], ed.data);
                    chk("d_error", m_d_error[di], ed.err);
                    if (ed.last) outst[di]--;
                end
            end
        end
    end

    // Stimulus: two random masters plus an in-order slave responder.
    initial begin : stimulus
        bit                busy [2], shown [2], af [2];
        int                left [2], total [2];
        logic [2:0]        cop [2], cparam [2];
        logic [SIZE_W-1:0] csize [2];
        logic [SRC_W-1:0]  csrc [2];
        logic [31:0]       caddr [2];
        bit                df, dshown, gen, rst_done, drained;
        int                pa, pd, pv, ps, nb, r;
        abeat_t            b;
        dbeat_t            d;

        reset = 1; s_a_ready = 0; s_d_valid = 0; s_d_opcode = 0; s_d_size = 0;
        s_d_source = 0; s_d_data = 0; s_d_error = 0;
        dshown = 0; rst_done = 0; drained = 0;
        for (int n = 0; n < 2; n++) begin
            busy[n] = 0; shown[n] = 0; left[n] = 0; total[n] = 0;
            cop[n] = 0; cparam[n] = 0; csize[n] = 0; csrc[n] = 0; caddr[n] = 0;
            m_a_valid[n] = 0; m_a_opcode[n] = 0; m_a_param[n] = 0; m_a_size[n] = 0;
            m_a_source[n] = 0; m_a_address[n] = 0; m_a_mask[n] = 0; m_a_data[n] = 0;
            m_d_ready[n] = 0;
        end
        repeat (3) @(posedge clock);
        #1 reset = 0;

        for (int cyc = 0; cyc < 7000; cyc++) begin
            @(negedge clock);
            for (int n = 0; n < 2; n++) af[n] = m_a_valid[n] && m_a_ready[n];
            df = s_d_valid && s_d_ready;
            @(posedge clock);
            #1;
            gen = (cyc < 4500);
            if (cyc < 1500)      begin pa = 75;  pd = 75;  pv = 60;  ps = 70;  end
            else if (cyc < 2500) begin pa = 100; pd = 100; pv = 100; ps = 100; end
            else                 begin pa = 80;  pd = 90;  pv = 50;  ps = 15;  end

            if (!rst_done && cyc > 3200) begin
                for (int n = 0; n < 2; n++)
                    if (busy[n] && cop[n] != 3'd4 && total[n] > 1 && left[n] < total[n] && !af[n])
                        rst_done = 1;
                if (rst_done) begin
                    reset = 1;
                    dshown = 0; s_d_valid = 0; slv_q.delete();
                    for (int n = 0; n < 2; n++) begin
                        busy[n] = 0; shown[n] = 0; m_a_valid[n] = 0;
                    end
                    repeat (2) begin @(posedge clock); #1; end
                    reset = 0;
                    continue;
                end
            end

            for (int n = 0; n < 2; n++) begin
                if (shown[n] && af[n]) begin
                    shown[n] = 0;
                    left[n]--;
                    if (left[n] == 0) begin
                        busy[n] = 0;
                        nb = (cop[n] == 3'd4) ? beats(int'(csize[n])) : 1;
                        for (int k = 0; k < nb; k++) begin
                            d.op   = (cop[n] == 3'd4) ? 3'd1 : 3'd0;
                            d.size = csize[n];
                            d.src  = {1'(n), csrc[n]};
                            d.data = $urandom;
                            d.err  = ($urandom_range(15) == 0);
                            d.last = (k == nb - 1);
                            slv_q.push_back(d);
                            exp_d[n].push_back(d);
                        end
                    end
                end
                if (!shown[n] && !busy[n] && gen && $urandom_range(99) < pv) begin
                    r = $urandom_range(2);
                    cop[n]    = (r == 0) ? 3'd4 : (r == 1) ? 3'd0 : 3'd1;
                    cparam[n] = 3'($urandom_range(7));
                    csize[n]  = SIZE_W'($urandom_range(4));
                    csrc[n]   = SRC_W'($urandom);
                    caddr[n]  = $urandom;
                    total[n]  = (cop[n] == 3'd4) ? 1 : beats(int'(csize[n]));
                    left[n]   = total[n];
                    busy[n]   = 1;
                end
                if (!shown[n] && busy[n] && $urandom_range(7) != 0) begin
                    b.op = cop[n]; b.param = cparam[n]; b.size = csize[n]; b.src = csrc[n];
                    b.addr = caddr[n]; b.mask = 4'($urandom); b.data = $urandom;
                    b.first = (left[n] == total[n]);
                    b.last  = (left[n] == 1);
                    m_a_opcode[n] = b.op;   m_a_param[n] = b.param;  m_a_size[n] = b.size;
                    m_a_source[n] = b.src;  m_a_address[n] = b.addr; m_a_mask[n] = b.mask;
                    m_a_data[n] = b.data;
                    exp_a[n].push_back(b);
                    shown[n] = 1;
                end
                m_a_valid[n] = shown[n];
                m_d_ready[n] = ($urandom_range(99) < pd);
            end

            if (dshown && df) begin
                void'(slv_q.pop_front());
                dshown = 0;
            end
            if (!dshown && slv_q.size() > 0 && $urandom_range(99) < ps) begin
                s_d_opcode = slv_q[0].op;   s_d_size = slv_q[0].size;
                s_d_source = slv_q[0].src;  s_d_data = slv_q[0].data;
                s_d_error  = slv_q[0].err;
                dshown = 1;
            end
            s_d_valid = dshown;
            s_a_ready = ($urandom_range(99) < pa);

            if (!gen && !busy[0] && !busy[1] && !dshown && slv_q.size() == 0) begin
                drained = 1;
                break;
            end
        end

        repeat (3) @(posedge clock);
        chk("drain_complete", drained, 1);
        chk("reset_injected", rst_done, 1);
        chk("exp_a0_empty", exp_a[0].size(), 0);
        chk("exp_a1_empty", exp_a[1].size(), 0);
        chk("exp_d0_empty", exp_d[0].size(), 0);
        chk("exp_d1_empty", exp_d[1].size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tl_ul_arb2.md
# tl_ul_arb2

Two-requester TileLink-UL arbiter that shares one slave port, the input of the width fragmenter/buffer pair in the SiFive E21 peripheral path, between two masters. Round-robin grant on A, burst lock for multi-beat PutFullData/PutPartialData, D-channel return routing by source MSB, and a per-master outstanding-transaction limit. No data buffering; A and D are combinational pass-through gated by the arbitration state.

## Interface
- `SRC_W`, default 1: per-master source width; slave source is `SRC_W+1` bits, with the master index in the MSB.
- `SIZE_W`, default 3: `a_size`/`d_size` width (log2 bytes; up to 128 B).
- `MAX_INFLIGHT`, default 2: maximum outstanding requests per master (1..15).
- `clock` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `mN_a_valid` in 1, `mN_a_ready` out 1 (N=0,1): master A handshake.
- `mN_a_opcode` in 3, `mN_a_param` in 3, `mN_a_size` in SIZE_W, `mN_a_source` in SRC_W, `mN_a_address` in 32, `mN_a_mask` in 4, `mN_a_data` in 32: master A fields.
- `mN_d_valid` out 1, `mN_d_ready` in 1: master D handshake.
- `mN_d_opcode` out 3, `mN_d_size` out SIZE_W, `mN_d_source` out SRC_W, `mN_d_data` out 32, `mN_d_error` out 1: master D fields.
- `s_a_valid` out 1, `s_a_ready` in 1, plus `s_a_*` out fields of the same widths as master A; `s_a_source` is SRC_W+1 bits.
- `s_d_valid` in 1, `s_d_ready` out 1, plus `s_d_*` in fields; `s_d_source` is SRC_W+1 bits.

## Operation
- Beats per message: `beats(size) = size>2 ? 1<<(size-2) : 1`. Applies to A when opcode is 0 or 1 (Put*), and to D when opcode is 1 (AccessAckData); all others are single-beat.
- Eligibility: master N is eligible iff `mN_a_valid && inflight[N] < MAX_INFLIGHT`.
- State IDLE:
  - Grant goes to the eligible master. If both are eligible, it goes to `rr_ptr`.
  - `s_a_*` muxes from the granted master. `s_a_valid` = granted master eligible.
  - `mN_a_ready = s_a_ready && grant==N && eligible[N]`; the non-granted master sees ready 0.
  - `s_a_source = {N, mN_a_source}`.
- IDLE -> LOCKED(N): on an A fire of a multi-beat message. Load `a_beats_left = beats-1`.
- In LOCKED(N), only master N is muxed, regardless of the other master's valid or the inflight limit. Each fire decrements `a_beats_left`. The last fire returns to IDLE.
- `rr_ptr` becomes `~N` on the last beat of any A message from N: a single-beat fire in IDLE, or the final beat in LOCKED.
- `inflight[N]`:
  - +1 on the first A beat of a message from N.
  - −1 on the last D beat routed to N.
  - Both events in the same cycle leave it unchanged.
  - It never exceeds MAX_INFLIGHT and never underflows. A D beat with count 0 is a protocol error: counter held at 0, flagged by an assertion.
- D routing: `idx = s_d_source[SRC_W]`.
  - `m[idx]_d_valid = s_d_valid`; the other master's valid is 0.
  - `s_d_ready = m[idx]_d_ready`.
  - `mN_d_source` = low SRC_W bits; the other D fields pass through.
  - A D beat counter tracks multi-beat AccessAckData to locate the last beat. D is never arbitrated: single slave, in order.

## Timing
- A and D paths have zero latency: valid, ready and fields are combinational. No register on the data path.
- State updates on the rising `clock` edge after a fire (`valid && ready`).
- Reset values: IDLE, `rr_ptr=0`, `a_beats_left=0`, `d_beats_left=0`, `inflight[0..1]=0`.
- While `reset` is high, `s_a_valid`, `m0/m1_a_ready`, `m0/m1_d_valid` and `s_d_ready` are forced to 0.
- Reset mid-burst drops the lock and all counts immediately. Recovery of upstream/downstream state is the system's responsibility.
- Once `s_a_valid` is asserted for a master, it is not withdrawn while that master holds valid. A grant may only switch in IDLE when no fire occurred that cycle.
- Simultaneous events:
  - An A last beat and a D last beat in the same cycle both apply.
  - Both masters requesting in the cycle the lock releases: the new grant uses the updated `rr_ptr`, effective the next cycle.

## Test plan
- **Round-robin:** m0 and m1 both issue continuous single-beat Get (size=2) with `s_a_ready=1` -> `s_a_source` MSB alternates 0,1,0,1… starting with 0 after reset; the inflight limit is honoured by returning D in the next cycle.
- **Burst lock:** m0 issues PutFullData size=4 (4 beats) while m1 is valid from beat 2 -> 4 consecutive m0 beats with `m1_a_ready=0`, then m1 is granted on cycle 5.
- **Backpressure:** `s_a_ready` toggles 1,0,1,0 mid-burst -> beats are not lost or duplicated, `a_beats_left` only changes on fires, and fields are stable while stalled.
- **Inflight limit:** MAX_INFLIGHT=2, m0 issues 3 Gets with no D returned -> third Get held (`m0_a_ready=0`) and m1 is served. A D to source {0,x} re-enables m0 the next cycle.
- **D routing:** `s_d_source=2'b10` AccessAckData size=3 (2 beats) -> `m1_d_valid` for 2 beats with `m1_d_source=0`, `m0_d_valid=0`, and `inflight[1]` decrements only after beat 2.
- **Reset mid-burst:** `reset` is asserted on beat 2 of a 4-beat Put -> the next cycle shows IDLE, `rr_ptr=0`, `inflight=0`, and all valids/readies are 0 during reset.
